mp_addsub_engine: RTL and testbench
===================================

// Module: mp_addsub_engine
// PURPOSE
//  Multi-cycle, multi-precision adder/subtractor. It is the responder side of the
//  start/subtract/in_a/in_b -> result/done handshake used by the big-integer datapath
//  and the hardware evaluation wrappers.
//  Operands are processed WORD bits per cycle with a registered carry chain. This keeps
//  timing independent of WIDTH.
// PARAMETERS
//  WIDTH   513  operand width in bits; result is WIDTH+1 bits
//  WORD    64   bits processed per cycle; NCHUNK = ceil((WIDTH+1)/WORD) (9 at defaults)
// PORTS
//  clk       in   1        rising-edge clock
//  resetn    in   1        reset, synchronous, active-low
//  start     in   1        request; sampled only in IDLE
//  subtract  in   1        0: a+b, 1: a-b; sampled together with start
//  in_a      in   WIDTH    operand A; sampled together with start
//  in_b      in   WIDTH    operand B; sampled together with start
//  result    out  WIDTH+1  sum/difference; registered, held until next completion
//  done      out  1        one-cycle pulse; result valid in that cycle
//  busy      out  1        high in RUN and DONE; start is ignored while high
// BEHAVIOUR
//  Reset (resetn=0 at a clock edge):
//   - state=IDLE; result=0; done=0; busy=0; internal operands, carry and chunk index cleared.
//   - Reset has priority over everything and aborts an in-flight operation with no done.
//  States:
//   - IDLE: on start=1, latch {in_a,in_b} zero-extended to NCHUNK*WORD bits, and latch subtract.
//     Carry-in = subtract. Chunk index=0. Go to RUN.
//   - RUN: each edge computes chunk i = A[i] + (B[i] ^ {WORD{sub}}) + carry and stores it
//     in an internal accumulator. The chunk's carry-out is registered. Index increments.
//     After chunk NCHUNK-1, copy accumulator[WIDTH:0] to result and go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE. A start in this cycle is ignored.
//  Latency:
//   - Start is sampled at edge E0; done is high in the cycle after edge E0+NCHUNK.
//   - At defaults this is 10 cycles from start to done.
//   - The next start is accepted no earlier than the cycle after done (throughput NCHUNK+2).
//  Arithmetic:
//   - result = (A + B) mod 2^(WIDTH+1), or (A - B) mod 2^(WIDTH+1).
//   - Add: result[WIDTH] is the carry out.
//   - Subtract: result[WIDTH]=1 iff A<B (two's-complement sign of the WIDTH+1 result).
//   - Bits above WIDTH in the last chunk are discarded.
//  result is unchanged during RUN/DONE-entry until the completion copy. It holds after done
//  until the next completion or reset.
//  Input changes while busy=1 have no effect on the operation in flight.
//  start held high continuously: operations repeat back-to-back, accepted each time state is IDLE.
//  subtract/operands are don't-care when start=0.
// TESTING
//  1 Reset: hold resetn=0 for 2 cycles -> result=0, done=0, busy=0.
//  2 Add 5+7: start=1 pulse -> done exactly 10 cycles later; result=12 during done and afterwards.
//  3 Carry chain: in_a=2^513-1, in_b=1, add -> result=2^513 (only bit 513 set).
//  4 Subtract equal operands: in_a=in_b=2^513-1, sub -> result=0 with done.
//    This matches the eval wrapper's data_ok pattern.
//  5 Borrow: in_a=0, in_b=1, sub -> result=2^514-1 (all 514 bits set).
//  6 Robustness, part a: start re-pulsed and operands changed at cycles 3 and 7 of a busy op
//    -> single done, original result.
//  6 Robustness, part b: resetn=0 at cycle 5 of an op -> no done, result=0.
//  6 Robustness, part c: start held high -> done every 11 cycles.

Source files
------------

// File: rtl/mp_addsub_engine.sv
// mp_addsub_engine: multi-cycle, multi-precision adder/subtractor.
// Computes (in_a + in_b) or (in_a - in_b) mod 2^(WIDTH+1). It handles WORD bits per
// cycle through a registered carry, so timing does not depend on WIDTH.
// Ports:
//   clk, resetn      rising-edge clock; synchronous active-low reset
//   start            request, sampled only while idle
//   subtract         0: a+b, 1: a-b (sampled with start)
//   in_a, in_b       WIDTH-bit operands (sampled with start)
//   result           WIDTH+1-bit registered result, held until the next completion
//   done             one-cycle pulse, result valid in that cycle
//   busy             high while an operation runs or completes; start is ignored then
module mp_addsub_engine #(
    parameter int unsigned WIDTH = 513,
    parameter int unsigned WORD  = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned NCHUNK = (WIDTH + WORD) / WORD;  // ceil((WIDTH+1)/WORD)
    localparam int unsigned EXT_W  = NCHUNK * WORD;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_nxt;

    logic [NCHUNK-1:0][WORD-1:0] op_a_q, op_b_q, acc_q, acc_nxt;
    logic                        sub_q;
    logic                        carry_q;
    logic [IDX_W-1:0]            idx_q;

    logic                        load_c, step_c, finish_c;
    logic                        done_nxt, busy_nxt;
    logic [WORD-1:0]             b_word_c;
    logic [WORD:0]               sum_c;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state_q;
        load_c    = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step_c   = 1'b1;
                busy_nxt = 1'b1;
                if (idx_q == LAST_IDX) begin
                    finish_c  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // One chunk of the ripple: subtraction is A + ~B + 1, the +1 entering as carry-in
    always_comb begin
        b_word_c = op_b_q[idx_q] ^ {WORD{sub_q}};
        sum_c    = (WORD+1)'(op_a_q[idx_q]) + (WORD+1)'(b_word_c) + (WORD+1)'(carry_q);
        acc_nxt  = acc_q;
        acc_nxt[idx_q] = sum_c[WORD-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= done_nxt;
            busy <= busy_nxt;
            if (load_c) begin
                op_a_q  <= EXT_W'(in_a);
                op_b_q  <= EXT_W'(in_b);
                sub_q   <= subtract;
                carry_q <= subtract;
                idx_q   <= '0;
            end
            if (step_c) begin
                acc_q   <= acc_nxt;
                carry_q <= sum_c[WORD];
                idx_q   <= idx_q + IDX_W'(1);
            end
            // Bits above WIDTH in the last chunk are dropped here
            if (finish_c) begin
                result <= (WIDTH+1)'(acc_nxt);
            end
        end
    end

endmodule

// File: tb/tb_mp_addsub_engine.sv
// Directed bench for mp_addsub_engine at default parameters (WIDTH=513, WORD=64).
module tb_mp_addsub_engine;

    localparam int unsigned W      = 513;
    localparam int          NCHUNK = 9;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         subtract;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W:0]   result;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    mp_addsub_engine #(.WIDTH(W), .WORD(64)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, scramble inputs afterwards, wait (bounded) for done.
    // lat counts falling edges after the one that follows the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output logic [W:0] r);
        @(negedge clk);
        in_a = a; in_b = b; subtract = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_a = ~a; in_b = ~b; subtract = ~s;
        lat = -1;
        r   = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                r   = result;
                break;
            end
        end
    endtask

    int           lat;
    logic [W:0]   r;
    logic [W-1:0] ones_w;
    logic [W:0]   exp_v;
    int           n_done;
    int           first_k;
    int           dk [3];

    initial begin
        resetn = 1'b0; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
        ones_w = '1;

        // 1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, '0);
        check("reset_done", (W+1)'(done), '0);
        check("reset_busy", (W+1)'(busy), '0);
        resetn = 1'b1;

        // 2 add 5+7
        run_op(W'(5), W'(7), 1'b0, lat, r);
        check("add_latency", (W+1)'(lat), (W+1)'(NCHUNK));
        check("add_result_at_done", r, (W+1)'(12));
        @(negedge clk);
        check("add_done_one_cycle", (W+1)'(done), '0);
        check("add_result_held", result, (W+1)'(12));
        check("add_busy_cleared", (W+1)'(busy), '0);

        // 3 carry across every chunk
        run_op(ones_w, W'(1), 1'b0, lat, r);
        exp_v = '0; exp_v[W] = 1'b1;
        check("carry_latency", (W+1)'(lat), (W+1)'(NCHUNK));
        check("carry_result", r, exp_v);

        // 4 equal-operand subtract
        run_op(ones_w, ones_w, 1'b1, lat, r);
        check("sub_equal_result", r, '0);

        // small subtracts both directions
        run_op(W'(7), W'(5), 1'b1, lat, r);
        check("sub_7_5", r, (W+1)'(2));
        run_op(W'(5), W'(7), 1'b1, lat, r);
        exp_v = '1; exp_v[0] = 1'b0;
        check("sub_5_7", r, exp_v);

        // 5 borrow through all chunks
        run_op('0, W'(1), 1'b1, lat, r);
        exp_v = '1;
        check("borrow_result", r, exp_v);

        // 6a start re-pulsed and operands changed mid-operation
        @(negedge clk);
        in_a = W'(100); in_b = W'(30); subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; first_k = -1; r = '0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 5) check("result_unchanged_in_run", result, exp_v);
            if (done) begin
                n_done++;
                if (first_k < 0) begin
                    first_k = k;
                    r = result;
                end
            end
            if (k == 3 || k == 7) begin
                start = 1'b1; in_a = W'(999); in_b = W'(1); subtract = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("robust_a_done_count", (W+1)'(n_done), (W+1)'(1));
        check("robust_a_latency", (W+1)'(first_k), (W+1)'(NCHUNK));
        check("robust_a_result", r, (W+1)'(130));

        // 6b reset mid-operation aborts with no done
        @(negedge clk);
        in_a = W'(5); in_b = W'(7); subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (k == 4) resetn = 1'b0;
            if (k == 5) resetn = 1'b1;
        end
        check("robust_b_no_done", (W+1)'(n_done), '0);
        check("robust_b_result", result, '0);
        check("robust_b_busy", (W+1)'(busy), '0);

        // 6c start held high: back-to-back operations
        @(negedge clk);
        in_a = W'(1); in_b = W'(2); subtract = 1'b0; start = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (n_done < 3) dk[n_done] = k;
                n_done++;
            end
        end
        start = 1'b0;
        check("robust_c_done_count", (W+1)'(n_done), (W+1)'(3));
        check("robust_c_first", (W+1)'(dk[0]), (W+1)'(NCHUNK + 1));
        check("robust_c_period1", (W+1)'(dk[1] - dk[0]), (W+1)'(11));
        check("robust_c_period2", (W+1)'(dk[2] - dk[1]), (W+1)'(11));
        check("robust_c_result", result, (W+1)'(3));
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
